// File: rtl/dot_prod_pkg.sv
// Shared defaults, derived widths and elaboration-time helpers for the
// dot_prod adder-tree datapath.
package dot_prod_pkg;

    localparam int DEF_XLEN_PIXEL    = 8;
    localparam int DEF_NUM_OF_PIXELS = 30;

    localparam int PROD_W = 2 * DEF_XLEN_PIXEL;
    localparam int ACC_W  = 4 * DEF_XLEN_PIXEL;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r = r + 1;
        end
        return r;
    endfunction

    // Element count at tree level s: ceil(n / 2^s).
    function automatic int level_count(input int n, input int s);
        return (n + (1 << s) - 1) >> s;
    endfunction

    // Bit-bus offset (in elements) of level s when all levels are packed end to end.
    function automatic int level_offset(input int n, input int s);
        int off;
        off = 0;
        for (int t = 0; t < s; t++) begin
            off = off + level_count(n, t);
        end
        return off;
    endfunction

endpackage

// File: rtl/dot_prod_add_level.sv
// One registered level of the adder tree: pairwise sums of M elements,
// with the odd trailing element forwarded unchanged.
module dot_prod_add_level #(
    parameter int M = 2,
    parameter int W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [M*W-1:0]             din,
    output logic [((M+1)/2)*W-1:0]     dout
);

    localparam int K = (M + 1) / 2;

    // NOTE: registers use non-blocking assignments so every level samples the
    // previous level's old value on the same edge; reset is synchronous here.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= '0;
        end else begin
            for (int j = 0; j < M / 2; j++) begin
                dout[j*W +: W] <= din[(2*j)*W +: W] + din[(2*j+1)*W +: W];
            end
            if (M % 2 == 1) begin
                dout[(K-1)*W +: W] <= din[(M-1)*W +: W];
            end
        end
    end

endmodule

// File: rtl/dot_prod.sv
// Pipelined unsigned dot product: registered element-wise products followed
// by clog2(N) registered adder-tree levels; one result per clock.
module dot_prod
    import dot_prod_pkg::*;
#(
    parameter int XLEN_PIXEL    = DEF_XLEN_PIXEL,
    parameter int NUM_OF_PIXELS = DEF_NUM_OF_PIXELS
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_OF_PIXELS*XLEN_PIXEL-1:0] x_test,
    input  logic [NUM_OF_PIXELS*XLEN_PIXEL-1:0] x_sv,
    output logic [4*XLEN_PIXEL-1:0]             mac_out
);

    localparam int N     = NUM_OF_PIXELS;
    localparam int PW    = 2 * XLEN_PIXEL;
    localparam int AW    = 4 * XLEN_PIXEL;
    localparam int L     = clog2(N);
    localparam int TOTAL = level_offset(N, L + 1);

    if (N < 1) begin : g_bad_n
        $error("dot_prod: NUM_OF_PIXELS must be at least 1");
    end
    if (PW + L > AW) begin : g_bad_width
        $error("dot_prod: accumulator too narrow for NUM_OF_PIXELS products");
    end

    logic [N*AW-1:0]  prod_q;
    wire  [TOTAL*AW-1:0] tree;

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                prod_q[i*AW +: AW] <= AW'(PW'(x_test[i*XLEN_PIXEL +: XLEN_PIXEL]) *
                                          PW'(x_sv[i*XLEN_PIXEL +: XLEN_PIXEL]));
            end
        end
    end

    // Level s occupies elements [level_offset(s), level_offset(s+1)) of the tree bus.
    assign tree[0 +: N*AW] = prod_q;

    for (genvar s = 1; s <= L; s++) begin : g_level
        localparam int M_IN  = level_count(N, s - 1);
        localparam int M_OUT = level_count(N, s);
        dot_prod_add_level #(
            .M (M_IN),
            .W (AW)
        ) u_level (
            .clk  (clk),
            .rst  (rst),
            .din  (tree[level_offset(N, s-1)*AW +: M_IN*AW]),
            .dout (tree[level_offset(N, s)*AW +: M_OUT*AW])
        );
    end

    assign mac_out = tree[level_offset(N, L)*AW +: AW];

endmodule

// File: tb/tb_dot_prod.sv
// Directed-vector bench for dot_prod with N=30 pixels of 8 bits; expected
// results are hand-computed and delayed through a 5-deep latency model.
module tb_dot_prod;

    localparam int X  = 8;
    localparam int N  = 30;
    localparam int VW = N * X;
    localparam int LAT = 5;

    logic          clk;
    logic          rst;
    logic [VW-1:0] x_test;
    logic [VW-1:0] x_sv;
    logic [31:0]   mac_out;

    int checks;
    int errors;
    logic [31:0] pipe [0:LAT];

    dot_prod #(
        .XLEN_PIXEL    (X),
        .NUM_OF_PIXELS (N)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .x_test  (x_test),
        .x_sv    (x_sv),
        .mac_out (mac_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [VW-1:0] splat(input logic [X-1:0] v);
        logic [VW-1:0] r;
        for (int i = 0; i < N; i++) r[i*X +: X] = v;
        return r;
    endfunction

    function automatic logic [VW-1:0] one_pix(input int idx, input logic [X-1:0] v);
        logic [VW-1:0] r;
        r = '0;
        r[idx*X +: X] = v;
        return r;
    endfunction

    // Apply one input sample across one rising edge; pipe[LAT] then holds the
    // value mac_out must show right now.
    task automatic tick(input logic [VW-1:0] xt, input logic [VW-1:0] xs,
                        input logic [31:0] e, input logic r);
        x_test = xt;
        x_sv   = xs;
        rst    = r;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i <= LAT; i++) pipe[i] = 32'd0;
        end else begin
            for (int i = LAT; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = e;
        end
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            tick({8{$urandom}}, {8{$urandom}}, 32'd0, 1'b1);
            checks++;
            if (mac_out !== 32'd0) begin
                errors++;
                $display("FAIL reset_hold cyc %0d: mac_out=%0d expected=0", c, mac_out);
            end
        end
        for (int c = 0; c < LAT + 2; c++) begin
            tick('0, '0, 32'd0, 1'b0);
            checks++;
            if (mac_out !== 32'd0) begin
                errors++;
                $display("FAIL reset_release cyc %0d: mac_out=%0d expected=0", c, mac_out);
            end
        end
    endtask

    task automatic test_sweep();
        for (int c = 0; c < 30 + LAT; c++) begin
            if (c < 30) tick(one_pix(0, X'(c)), one_pix(0, X'(c + 1)), 32'(c * (c + 1)), 1'b0);
            else        tick('0, '0, 32'd0, 1'b0);
            checks++;
            if (mac_out !== pipe[LAT]) begin
                errors++;
                $display("FAIL sweep cyc %0d: mac_out=%0d expected=%0d", c, mac_out, pipe[LAT]);
            end
        end
    endtask

    task automatic test_full_vectors();
        logic [VW-1:0] ramp;
        for (int i = 0; i < N; i++) ramp[i*X +: X] = X'(i + 1);
        for (int c = 0; c < 2 + LAT; c++) begin
            case (c)
                0:       tick(splat(8'd255), splat(8'd255), 32'd1950750, 1'b0);
                1:       tick(ramp, splat(8'd1), 32'd465, 1'b0);
                default: tick('0, '0, 32'd0, 1'b0);
            endcase
            checks++;
            if (mac_out !== pipe[LAT]) begin
                errors++;
                $display("FAIL full_vectors cyc %0d: mac_out=%0d expected=%0d", c, mac_out, pipe[LAT]);
            end
        end
    endtask

    task automatic test_odd_passthrough();
        for (int c = 0; c < 2 + LAT; c++) begin
            case (c)
                0:       tick(one_pix(29, 8'd7), one_pix(29, 8'd9), 32'd63, 1'b0);
                1:       tick(one_pix(28, 8'd2), one_pix(28, 8'd3), 32'd6, 1'b0);
                default: tick('0, '0, 32'd0, 1'b0);
            endcase
            checks++;
            if (mac_out !== pipe[LAT]) begin
                errors++;
                $display("FAIL odd_passthrough cyc %0d: mac_out=%0d expected=%0d", c, mac_out, pipe[LAT]);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 10 + LAT; c++) begin
            if (c < 10 && c % 2 == 0) tick(splat(8'd255), splat(8'd255), 32'd1950750, 1'b0);
            else                      tick('0, '0, 32'd0, 1'b0);
            checks++;
            if (mac_out !== pipe[LAT]) begin
                errors++;
                $display("FAIL back_to_back cyc %0d: mac_out=%0d expected=%0d", c, mac_out, pipe[LAT]);
            end
        end
    endtask

    task automatic test_mid_reset();
        for (int c = 0; c < 3; c++) tick(splat(8'd255), splat(8'd255), 32'd1950750, 1'b0);
        tick(splat(8'd255), splat(8'd255), 32'd0, 1'b1);
        checks++;
        if (mac_out !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset_edge: mac_out=%0d expected=0", mac_out);
        end
        for (int c = 0; c < 1 + LAT + 1; c++) begin
            if (c == 1) tick(one_pix(3, 8'd5), one_pix(3, 8'd6), 32'd30, 1'b0);
            else        tick('0, '0, 32'd0, 1'b0);
            checks++;
            if (mac_out !== pipe[LAT]) begin
                errors++;
                $display("FAIL mid_reset_after cyc %0d: mac_out=%0d expected=%0d", c, mac_out, pipe[LAT]);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i <= LAT; i++) pipe[i] = 32'd0;
        rst    = 1'b1;
        x_test = '0;
        x_sv   = '0;

        test_reset();
        test_sweep();
        test_full_vectors();
        test_odd_passthrough();
        test_back_to_back();
        test_mid_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
